// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: forwarding select codes and the
// scoreboard slot record tracked for EX, MEM and WB.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       v;
    logic [4:0] rw;
    logic       wr;
    logic       ld;
  } slot_t;

endpackage

// File: rtl/hazard_slot_match.sv
// Live-and-match compare of one scoreboard slot against the ID source registers.
module hazard_slot_match
  import hazard_ctrl_pkg::*;
(
  input  slot_t      slot,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hit_rs,
  output logic       hit_rt
);

  logic live;

  // $0 is hardwired, so a slot writing it can neither stall nor forward
  assign live   = slot.v & slot.wr & (slot.rw != 5'd0);
  assign hit_rs = live & (slot.rw == rs);
  assign hit_rt = live & (slot.rw == rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, branch/jump squash, registered EX forward
// selects and saturating event counters, driven from a private EX/MEM/WB scoreboard.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_ID,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             uses_rs_ID,
  input  logic             uses_rt_ID,
  input  logic [4:0]       Rw_ID,
  input  logic             RegWr_ID,
  input  logic             MemToReg_ID,
  input  logic             take_Ex,
  input  logic             ext_hold,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic [1:0]       fwdA_Ex,
  output logic [1:0]       fwdB_Ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t sb_ex, sb_mem, sb_wb;
  logic  ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
  logic  lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // A load in EX has no result yet; WB writes the register file early, so RF suffices
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_ld,
                                         input logic mem_hit, input logic wb_hit);
    if (ex_hit && !ex_ld) return FWD_MEM;
    if (mem_hit)          return FWD_WB;
    if (wb_hit)           return FWD_RF;
    return FWD_RF;
  endfunction

  hazard_slot_match u_match_ex (
    .slot(sb_ex), .rs(Rs_ID), .rt(Rt_ID), .hit_rs(ex_hit_rs), .hit_rt(ex_hit_rt)
  );
  hazard_slot_match u_match_mem (
    .slot(sb_mem), .rs(Rs_ID), .rt(Rt_ID), .hit_rs(mem_hit_rs), .hit_rt(mem_hit_rt)
  );
  hazard_slot_match u_match_wb (
    .slot(sb_wb), .rs(Rs_ID), .rt(Rt_ID), .hit_rs(wb_hit_rs), .hit_rt(wb_hit_rt)
  );

  assign lu = valid_ID & sb_ex.ld &
              ((uses_rs_ID & ex_hit_rs) | (uses_rt_ID & ex_hit_rt));

  // ID stage: combinational pipeline-register controls, freeze > squash > stall
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    if (ext_hold) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
    end else if (take_Ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // ID/EX boundary: scoreboard advance, forward selects and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      fwdA_Ex   <= FWD_RF;
      fwdB_Ex   <= FWD_RF;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!ext_hold) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      if (idex_bubble) begin
        sb_ex   <= '0;
        fwdA_Ex <= FWD_RF;
        fwdB_Ex <= FWD_RF;
      end else begin
        sb_ex   <= slot_t'{v: valid_ID, rw: Rw_ID, wr: RegWr_ID, ld: MemToReg_ID};
        fwdA_Ex <= fwd_sel(ex_hit_rs, sb_ex.ld, mem_hit_rs, wb_hit_rs);
        fwdB_Ex <= fwd_sel(ex_hit_rt, sb_ex.ld, mem_hit_rt, wb_hit_rt);
      end
      if (lu && !take_Ex) stall_cnt <= sat_inc(stall_cnt);
      if (take_Ex)        flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule
